// File: rtl/sift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sift_pkg
// Description : Shared constants, state encoding and direction-sector helper
//               for the Sobel gradient magnitude/direction stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sift_pkg;

    localparam int IMG_W_DEF = 512;
    localparam int IMG_H_DEF = 512;
    localparam int ADDR_W    = 18;

    // Direction sectors, numbered counter-clockwise from +gx
    localparam logic [2:0] DIR_E  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_N  = 3'd2;
    localparam logic [2:0] DIR_NW = 3'd3;
    localparam logic [2:0] DIR_W  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_S  = 3'd6;
    localparam logic [2:0] DIR_SE = 3'd7;

    // tan(22.5) ~ 53/128 and tan(67.5) ~ 309/128
    localparam int TAN22_NUM = 53;
    localparam int TAN67_NUM = 309;
    localparam int TAN_DEN   = 128;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Quantise a gradient into one of eight sectors from its absolute
    // components and sign bits; a zero gradient maps to sector 0.
    function automatic logic [2:0] grad_sector(
        input logic [9:0] ax,
        input logic [9:0] ay,
        input logic       neg_x,
        input logic       neg_y
    );
        logic [18:0] ty;
        logic [18:0] tx22;
        logic [18:0] tx67;
        logic [2:0]  sec;
        ty   = 19'(ay) * 19'(TAN_DEN);
        tx22 = 19'(ax) * 19'(TAN22_NUM);
        tx67 = 19'(ax) * 19'(TAN67_NUM);
        if (ax == 10'd0 && ay == 10'd0) begin
            sec = DIR_E;
        end else if (ty < tx22) begin
            sec = neg_x ? DIR_W : DIR_E;
        end else if (ty > tx67) begin
            sec = neg_y ? DIR_S : DIR_N;
        end else if (!neg_x) begin
            sec = neg_y ? DIR_SE : DIR_NE;
        end else begin
            sec = neg_y ? DIR_SW : DIR_NW;
        end
        return sec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sift_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : sift_line_buf
// Description : DEPTH x 8-bit line delay. Addressed by the current column so
//               the read returns the pixel written one line earlier at the
//               same column; the write replaces it in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sift_line_buf #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);
    logic [7:0] mem [DEPTH];

    assign dout = mem[addr];

    // Store the new pixel over the one just read out
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sift_grad_mag_dir.sv
`default_nettype none
// ============================================================================
// Module      : sift_grad_mag_dir
// Description : Raster-stream 3x3 Sobel gradient stage. Produces saturated
//               8-bit magnitude, 3-bit direction sector and centre address,
//               3 cycles after the accepting clock, one result per cycle.
//               Optional macro SIFT_GRAD_THRESH_EN zeroes mag/dir for
//               magnitudes below MAG_THR.
// Revision    : 1.0 - initial release
// ============================================================================
module sift_grad_mag_dir
    import sift_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int MAG_THR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic [7:0]        pix,
    output logic [7:0]        mag,
    output logic [5:0]        dir,
    output logic [ADDR_W-1:0] addr,
    output logic              out_valid
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
`ifdef SIFT_GRAD_THRESH_EN
    localparam int THR = MAG_THR;
`else
    // Threshold disabled: a floor of zero never suppresses anything
    localparam int THR = MAG_THR * 0;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   w_pos_col;
    logic [RW-1:0]   w_pos_row;
    logic            w_accept;
    logic            w_last_col;
    logic            w_last_pix;
    logic [7:0]      w_lb0_q;
    logic [7:0]      w_lb1_q;

    // Window shift registers: p = row r-2, q = row r-1, s = row r
    logic [7:0]      r_sh_p [3];
    logic [7:0]      r_sh_q [3];
    logic [7:0]      r_sh_s [3];
    logic            r_v0;
    logic [RW-1:0]   r_crow;
    logic [CW-1:0]   r_ccol;

    logic [7:0]      r_st1_p [3];
    logic [7:0]      r_st1_q [3];
    logic [7:0]      r_st1_s [3];
    logic            r_v1;
    logic [ADDR_W-1:0] r_st1_addr;

    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic signed [10:0] r_gx;
    logic signed [10:0] r_gy;
    logic            r_v2;
    logic [ADDR_W-1:0] r_st2_addr;

    logic [9:0]      w_ax;
    logic [9:0]      w_ay;
    logic [10:0]     w_sum;
    logic [7:0]      w_mag;
    logic [2:0]      w_sec;

    function automatic logic signed [10:0] px_ext(input logic [7:0] v);
        return $signed({3'b000, v});
    endfunction

    // Position of the pixel being accepted; sof forces (0,0)
    always_comb begin
        w_accept   = pix_valid && (sof || (r_state == ST_RUN));
        w_pos_col  = sof ? '0 : r_col;
        w_pos_row  = sof ? '0 : r_row;
        w_last_col = (w_pos_col == CW'(IMG_W - 1));
        w_last_pix = w_last_col && (w_pos_row == RW'(IMG_H - 1));
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter on sof, leave after the last pixel of the frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (pix_valid && sof)        w_state_nxt = ST_RUN;
            ST_RUN:  if (w_accept && w_last_pix)  w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    // Raster column/row counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_pix ? '0 : w_pos_row + 1'b1;
            end else begin
                r_col <= w_pos_col + 1'b1;
                r_row <= w_pos_row;
            end
        end
    end

    sift_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk  (clk),
        .en   (w_accept),
        .addr (w_pos_col),
        .din  (pix),
        .dout (w_lb0_q)
    );

    sift_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk  (clk),
        .en   (w_accept),
        .addr (w_pos_col),
        .din  (w_lb0_q),
        .dout (w_lb1_q)
    );

    // Accept: shift the 3x3 window and flag interior centres
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_p <= '{default: '0};
            r_sh_q <= '{default: '0};
            r_sh_s <= '{default: '0};
            r_v0   <= 1'b0;
            r_crow <= '0;
            r_ccol <= '0;
        end else begin
            r_v0 <= w_accept && (w_pos_row >= RW'(2)) && (w_pos_col >= CW'(2));
            if (w_accept) begin
                r_sh_p <= '{r_sh_p[1], r_sh_p[2], w_lb1_q};
                r_sh_q <= '{r_sh_q[1], r_sh_q[2], w_lb0_q};
                r_sh_s <= '{r_sh_s[1], r_sh_s[2], pix};
                r_crow <= w_pos_row - 1'b1;
                r_ccol <= w_pos_col - 1'b1;
            end
        end
    end

    // Stage 1: register the window and form the centre address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st1_p    <= '{default: '0};
            r_st1_q    <= '{default: '0};
            r_st1_s    <= '{default: '0};
            r_v1       <= 1'b0;
            r_st1_addr <= '0;
        end else begin
            r_st1_p    <= r_sh_p;
            r_st1_q    <= r_sh_q;
            r_st1_s    <= r_sh_s;
            r_v1       <= r_v0;
            r_st1_addr <= ADDR_W'(r_crow) * ADDR_W'(IMG_W) + ADDR_W'(r_ccol);
        end
    end

    // Sobel kernels on the registered window
    always_comb begin
        w_gx = (px_ext(r_st1_p[2]) + (px_ext(r_st1_q[2]) <<< 1) + px_ext(r_st1_s[2]))
             - (px_ext(r_st1_p[0]) + (px_ext(r_st1_q[0]) <<< 1) + px_ext(r_st1_s[0]));
        w_gy = (px_ext(r_st1_s[0]) + (px_ext(r_st1_s[1]) <<< 1) + px_ext(r_st1_s[2]))
             - (px_ext(r_st1_p[0]) + (px_ext(r_st1_p[1]) <<< 1) + px_ext(r_st1_p[2]));
    end

    // Stage 2: register gx/gy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gx       <= '0;
            r_gy       <= '0;
            r_v2       <= 1'b0;
            r_st2_addr <= '0;
        end else begin
            r_gx       <= w_gx;
            r_gy       <= w_gy;
            r_v2       <= r_v1;
            r_st2_addr <= r_st1_addr;
        end
    end

    // L1 magnitude with saturation, sector quantisation, optional floor
    always_comb begin
        w_ax  = r_gx[10] ? 10'(-r_gx) : r_gx[9:0];
        w_ay  = r_gy[10] ? 10'(-r_gy) : r_gy[9:0];
        w_sum = {1'b0, w_ax} + {1'b0, w_ay};
        w_mag = (w_sum > 11'd255) ? 8'd255 : w_sum[7:0];
        w_sec = grad_sector(w_ax, w_ay, r_gx[10], r_gy[10]);
        if (int'(w_sum) < THR) begin
            w_mag = '0;
            w_sec = DIR_E;
        end
    end

    // Stage 3: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag       <= '0;
            dir       <= '0;
            addr      <= '0;
            out_valid <= 1'b0;
        end else begin
            mag       <= w_mag;
            dir       <= {3'b000, w_sec};
            addr      <= r_st2_addr;
            out_valid <= r_v2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sift_grad_mag_dir.sv
`default_nettype none
// ============================================================================
// Module      : tb_sift_grad_mag_dir
// Description : Self-checking bench for sift_grad_mag_dir on an 8x8 image.
//               Frame vectors from a table plus hand-written restart/reset
//               sequences; every output is matched against a queued
//               expectation including its arrival cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sift_grad_mag_dir;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int THR = 50;
`ifdef SIFT_GRAD_THRESH_EN
    localparam int RAMP5_MAG = 0;
`else
    localparam int RAMP5_MAG = 40;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix = 8'd0;
    logic [7:0]  mag;
    logic [5:0]  dir;
    logic [17:0] addr;
    logic        out_valid;

    sift_grad_mag_dir #(.IMG_W(W), .IMG_H(H), .MAG_THR(THR)) dut (
        .clk       (clk),
        .rst       (rst),
        .sof       (sof),
        .pix_valid (pix_valid),
        .pix       (pix),
        .mag       (mag),
        .dir       (dir),
        .addr      (addr),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int mag;
        int dir;
        int cyc;
    } exp_t;

    typedef struct {
        int pat;
        bit gap;
        int n_out;
        int first;
        int last;
        int sa;
        int smag;
        int sdir;
        int sb;
        int sbmag;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   img [H][W];
    int   errors = 0;
    int   checks = 0;
    int   out_cnt = 0;
    int   first_addr = -1;
    int   last_addr = -1;
    int   cap_mag [64];
    int   cap_dir [64];
    int   tr = 0;
    int   tc = 0;
    bit   trun = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference Sobel for the window whose bottom-right pixel is (r,c)
    function automatic void model(input int r, input int c, output int m, output int d);
        int gx, gy, ax, ay, s;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        s  = ax + ay;
        m  = (s > 255) ? 255 : s;
        if (gx == 0 && gy == 0)      d = 0;
        else if (128*ay < 53*ax)     d = (gx < 0) ? 4 : 0;
        else if (128*ay > 309*ax)    d = (gy < 0) ? 6 : 2;
        else if (gx >= 0)            d = (gy >= 0) ? 1 : 7;
        else                         d = (gy >= 0) ? 3 : 5;
`ifdef SIFT_GRAD_THRESH_EN
        if (s < THR) begin
            m = 0;
            d = 0;
        end
`endif
    endfunction

    // Drive one valid pixel and queue the output it should produce
    task automatic drive_px(input bit s, input int p);
        exp_t e;
        int   m, d;
        @(negedge clk);
        sof       = s;
        pix_valid = 1'b1;
        pix       = p[7:0];
        if (s) begin
            tr = 0; tc = 0; trun = 1'b1;
        end
        if (trun) begin
            if (tr >= 2 && tc >= 2) begin
                model(tr, tc, m, d);
                e.addr = (tr-1)*W + (tc-1);
                e.mag  = m;
                e.dir  = d;
                e.cyc  = cyc + 4;
                exp_q.push_back(e);
            end
            if (tc == W-1) begin
                tc = 0;
                if (tr == H-1) begin
                    tr = 0; trun = 1'b0;
                end else begin
                    tr++;
                end
            end else begin
                tc++;
            end
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sof       = 1'b0;
            pix_valid = 1'b0;
        end
    endtask

    task automatic send_rc(input int r, input int c, input bit gap);
        drive_px(r == 0 && c == 0, img[r][c]);
        if (gap) drive_idle(1);
    endtask

    task automatic clr_stats();
        out_cnt = 0;
        first_addr = -1;
        last_addr = -1;
        for (int i = 0; i < 64; i++) begin
            cap_mag[i] = -1;
            cap_dir[i] = -1;
        end
    endtask

    task automatic fill(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (pat)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c < 4) ? 0 : 200;
                    2: img[r][c] = (r < 4) ? 0 : 40;
                    3: img[r][c] = 10*c;
                    4: img[r][c] = 5*c;
                    5: img[r][c] = 10*(r+c);
                    6: img[r][c] = 70 - 10*c + 10*r;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    // Output monitor: every strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (out_valid) begin
            out_cnt++;
            if (first_addr < 0) first_addr = int'(addr);
            last_addr = int'(addr);
            if (addr < 18'd64) begin
                cap_mag[addr] = int'(mag);
                cap_dir[addr] = int'(dir);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: addr=%0d mag=%0d dir=%0d cyc=%0d, required no output",
                         addr, mag, dir, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(addr) != mon_e.addr || int'(mag) != mon_e.mag ||
                    int'(dir) != mon_e.dir || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL out: got addr=%0d mag=%0d dir=%0d cyc=%0d, required addr=%0d mag=%0d dir=%0d cyc=%0d",
                             addr, mag, dir, cyc, mon_e.addr, mon_e.mag, mon_e.dir, mon_e.cyc);
                end
            end
        end
    end

    vec_t vecs [9];

    initial begin
        vecs[0] = '{0, 1'b0, 36, 9, 54, 27, 0,   0, 9,  0};
        vecs[1] = '{1, 1'b0, 36, 9, 54, 11, 255, 0, 10, 0};
        vecs[2] = '{1, 1'b1, 36, 9, 54, 12, 255, 0, 13, 0};
        vecs[3] = '{2, 1'b0, 36, 9, 54, 25, 160, 2, 17, 0};
        vecs[4] = '{3, 1'b0, 36, 9, 54, 20, 80,  0, 54, 80};
        vecs[5] = '{4, 1'b0, 36, 9, 54, 20, RAMP5_MAG, 0, 9, RAMP5_MAG};
        vecs[6] = '{5, 1'b0, 36, 9, 54, 9,  160, 1, 54, 160};
        vecs[7] = '{6, 1'b0, 36, 9, 54, 9,  160, 3, 54, 160};
        vecs[8] = '{7, 1'b0, 36, 9, 54, -1, 0,   0, -1, 0};

        // Reset values
        clr_stats();
        drive_idle(2);
        #1;
        chk("reset_mag", int'(mag), 0);
        chk("reset_dir", int'(dir), 0);
        chk("reset_addr", int'(addr), 0);
        chk("reset_valid", int'(out_valid), 0);
        rst = 1'b0;

        // Pixels without sof while idle are ignored
        for (int i = 0; i < 5; i++) drive_px(1'b0, 50);
        drive_idle(8);
        chk("idle_ignored", out_cnt, 0);

        // Table of whole frames
        for (int v = 0; v < 9; v++) begin
            clr_stats();
            fill(vecs[v].pat);
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    send_rc(r, c, vecs[v].gap);
            drive_idle(8);
            chk($sformatf("v%0d_count", v), out_cnt, vecs[v].n_out);
            chk($sformatf("v%0d_first", v), first_addr, vecs[v].first);
            chk($sformatf("v%0d_last", v), last_addr, vecs[v].last);
            chk($sformatf("v%0d_drain", v), exp_q.size(), 0);
            if (vecs[v].sa >= 0) begin
                chk($sformatf("v%0d_mag@%0d", v, vecs[v].sa), cap_mag[vecs[v].sa], vecs[v].smag);
                chk($sformatf("v%0d_dir@%0d", v, vecs[v].sa), cap_dir[vecs[v].sa], vecs[v].sdir);
                chk($sformatf("v%0d_mag@%0d", v, vecs[v].sb), cap_mag[vecs[v].sb], vecs[v].sbmag);
            end
        end

        // sof mid-frame abandons the partial frame and restarts at (0,0)
        clr_stats();
        fill(5);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                send_rc(r, c, 1'b0);
        for (int c = 0; c < 3; c++) send_rc(4, c, 1'b0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_rc(r, c, 1'b0);
        drive_idle(8);
        chk("restart_count", out_cnt, 13 + 36);
        chk("restart_last", last_addr, 54);
        chk("restart_drain", exp_q.size(), 0);

        // Asynchronous reset mid row 5, then a fresh frame
        fill(1);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < W; c++)
                send_rc(r, c, 1'b0);
        for (int c = 0; c < 4; c++) send_rc(5, c, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        pix_valid = 1'b0;
        sof = 1'b0;
        exp_q.delete();
        trun = 1'b0;
        #1;
        chk("rst_valid_clear", int'(out_valid), 0);
        clr_stats();
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive_px(1'b0, 77);
        fill(2);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++)
                send_rc(r, c, 1'b0);
        drive_idle(5);
        chk("rst_quiet_rows01", out_cnt, 0);
        for (int r = 2; r < H; r++)
            for (int c = 0; c < W; c++)
                send_rc(r, c, 1'b0);
        drive_idle(8);
        chk("rst_new_first", first_addr, 9);
        chk("rst_new_count", out_cnt, 36);
        chk("rst_new_mag@25", cap_mag[25], 160);
        chk("rst_new_dir@25", cap_dir[25], 2);
        chk("rst_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
